// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a registered single-entry response buffer each.
// One cycle from grant to response; a full, unread buffer blocks only its own requester, and a same-cycle drain plus grant refills it with no bubble.
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,
  input  logic [4:0]        req0_sa,
  input  logic [4:0]        req0_op,
  input  logic [TAG_W-1:0]  req0_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_y,
  output logic              rsp0_zero,
  output logic              rsp0_illegal,
  output logic [TAG_W-1:0]  rsp0_tag,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,
  input  logic [4:0]        req1_sa,
  input  logic [4:0]        req1_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_y,
  output logic              rsp1_zero,
  output logic              rsp1_illegal,
  output logic [TAG_W-1:0]  rsp1_tag,

  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [4:0]        alu_sa,
  output logic [4:0]        alu_op,
  input  logic [31:0]       alu_y,
  input  logic              alu_zero,

  output logic [15:0]       grant_cnt
);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [4:0]       sa;
    logic [4:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      y;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  function automatic logic op_illegal(input logic [4:0] op);
    logic ill;
    case (op)
      5'b00111, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01101, 5'b10000: ill = 1'b0;
      default:            ill = 1'b1;
    endcase
    return ill;
  endfunction

  req_t        req_dat [2];
  logic [1:0]  req_vld;
  logic [1:0]  rsp_rdy;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        any_grant;
  req_t        sel_req;

  rsp_t        rsp_q [2];
  rsp_t        rsp_d [2];
  logic [1:0]  rsp_vld_q;
  logic [1:0]  rsp_vld_d;
  logic        last_grant_q;
  logic        last_grant_d;
  logic [15:0] grant_cnt_q;
  logic [15:0] grant_cnt_d;

  always_comb begin
    req_dat[0] = '{a: req0_a, b: req0_b, sa: req0_sa, op: req0_op, tag: req0_tag};
    req_dat[1] = '{a: req1_a, b: req1_b, sa: req1_sa, op: req1_op, tag: req1_tag};
    req_vld    = {req1_valid, req0_valid};
    rsp_rdy    = {rsp1_ready, rsp0_ready};
  end

  // A buffer may accept a new result when it is empty or being drained this cycle.
  always_comb begin
    elig      = req_vld & (~rsp_vld_q | rsp_rdy) & {2{~flush}};
    grant[0]  = elig[0] & (~elig[1] | last_grant_q);
    grant[1]  = elig[1] & (~elig[0] | ~last_grant_q);
    any_grant = |grant;
    sel_req   = grant[1] ? req_dat[1] : req_dat[0];
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_sa = '0;
    alu_op = '0;
    if (any_grant) begin
      alu_a  = sel_req.a;
      alu_b  = sel_req.b;
      alu_sa = sel_req.sa;
      alu_op = sel_req.op;
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rsp_d[n]     = rsp_q[n];
      rsp_vld_d[n] = rsp_vld_q[n];
      if (flush) begin
        rsp_vld_d[n] = 1'b0;
      end else if (grant[n]) begin
        rsp_d[n]     = '{y: alu_y, zero: alu_zero,
                         illegal: op_illegal(req_dat[n].op), tag: req_dat[n].tag};
        rsp_vld_d[n] = 1'b1;
      end else if (rsp_rdy[n]) begin
        rsp_vld_d[n] = 1'b0;
      end
    end

    last_grant_d = last_grant_q;
    if (flush) begin
      last_grant_d = 1'b1;
    end else if (any_grant) begin
      last_grant_d = grant[1];
    end

    grant_cnt_d = grant_cnt_q;
    if (any_grant && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < 2; n++) begin
        rsp_q[n] <= '0;
      end
      rsp_vld_q    <= '0;
      last_grant_q <= 1'b1;
      grant_cnt_q  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        rsp_q[n] <= rsp_d[n];
      end
      rsp_vld_q    <= rsp_vld_d;
      last_grant_q <= last_grant_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];

  assign rsp0_valid   = rsp_vld_q[0];
  assign rsp0_y       = rsp_q[0].y;
  assign rsp0_zero    = rsp_q[0].zero;
  assign rsp0_illegal = rsp_q[0].illegal;
  assign rsp0_tag     = rsp_q[0].tag;

  assign rsp1_valid   = rsp_vld_q[1];
  assign rsp1_y       = rsp_q[1].y;
  assign rsp1_zero    = rsp_q[1].zero;
  assign rsp1_illegal = rsp_q[1].illegal;
  assign rsp1_tag     = rsp_q[1].tag;

  assign grant_cnt    = grant_cnt_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. two issue slots or the main pipe plus a branch/address helper.
- Arbitrates round-robin, drives the external ALU operand/op ports, and registers each result into a per-requester single-entry response buffer with its own valid/ready handshake.
- Sits between the execute-stage issue logic and the ALU instance. Adds one cycle of latency.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous reset, active low
flush  in  1  synchronous pipeline flush
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a, req0_b  in  32  operands
req0_sa  in  5  shift amount
req0_op  in  5  ALU opcode
req0_tag  in  TAG_W  request tag
rsp0_valid  out  1  result buffer 0 holds a result
rsp0_ready  in  1  consumer 0 takes result
rsp0_y  out  32  result
rsp0_zero  out  1  result equals zero
rsp0_illegal  out  1  opcode not in supported set
rsp0_tag  out  TAG_W  tag of buffered result
req1_* / rsp1_*  same as requester 0, for requester 1
alu_a, alu_b  out  32  operands to ALU
alu_sa, alu_op  out  5  shift amount and opcode to ALU
alu_y  in  32  ALU result (combinational)
alu_zero  in  1  ALU zero flag
grant_cnt  out  16  saturating count of granted cycles

Behaviour:
- Reset (resetn=0, asynchronous): rspN_valid=0; rspN_y=0; rspN_zero=0; rspN_illegal=0; rspN_tag=0; last_grant=1, so requester 0 wins first; grant_cnt=0.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready) & ~flush.
- Arbitration, combinational:
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - At most one grant per cycle.
- reqN_ready = grantN. It may depend combinationally on reqN_valid. Requesters must hold valid and operands until ready.
- ALU drive:
  - On a grant, alu_a/b/sa/op = granted requester's fields.
  - With no grant, all four are driven 0. Opcode 0 yields y=0 in the ALU.
- Capture, next rising edge after a grant:
  - rspN_y <= alu_y; rspN_zero <= alu_zero; rspN_tag <= reqN_tag; rspN_valid <= 1.
  - rspN_illegal <= 1 iff reqN_op is not in {00111, 00001, 00010, 00011, 00100, 01000, 01001, 01010, 01011, 01100, 01101, 10000}.
  - Illegal ops still complete with whatever the ALU returns (0 for unsupported codes).
- Latency: request accepted in cycle T, response visible in cycle T+1. Throughput is one op per cycle total.
- Response drain:
  - rspN_valid clears when rspN_valid & rspN_ready and no grantN in the same cycle.
  - Drain and new grantN in the same cycle: valid stays 1 and the data is replaced (back-to-back, no bubble).
  - A full buffer with rspN_ready=0 blocks requester N only. The other requester keeps being served.
- last_grant updates to the granted index on every grant, including single-eligible grants. It is unchanged on idle cycles.
- flush:
  - Same cycle: suppresses all grants; all reqN_ready=0.
  - Next edge: rsp0_valid=rsp1_valid=0 (data regs may retain values); last_grant <= 1.
  - flush wins over a simultaneous drain or grant.
- grant_cnt increments by 1 on each grant cycle and saturates at 16'hFFFF. It is cleared only by reset, not by flush.
- Reset mid-operation: in-flight grant is dropped, no response is produced, and all state returns to reset values immediately.

Test Plan:
- Basic path: after reset, req0 add (op=10000) a=5, b=7, tag=3 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, y=12, zero=0, illegal=0, tag=3; grant_cnt=1.
- Round-robin: both valid continuously, rsp ready=1 -> grants alternate 0,1,0,1. req1 sll (op=01000) b=1, sa=4 returns y=16. grant_cnt=4 after 4 cycles.
- Backpressure: rsp0_valid=1, rsp0_ready=0, both requesting -> req0_ready=0 every cycle; req1 granted every cycle. When rsp0_ready rises, req0 is granted in the same cycle and rsp0 is replaced without a bubble.
- Illegal and zero: req1 op=11111, a=b=1 -> rsp1 y=0, zero=1, illegal=1. req0 and (op=00111) a=F0, b=0F -> y=0, zero=1, illegal=0.
- Flush: both responses pending, flush=1 with both requesting -> no ready that cycle; next cycle rsp valids=0; next contention is granted to requester 0.
- Async reset: assert resetn=0 mid-cycle with a grant active -> outputs go to reset values without a clock edge; no response after release.
